// File: rtl/addtree_operand_loader.sv
// addtree_operand_loader
//
// Serial-to-parallel operand loader in front of the 4-input adder tree.
// It accepts one WIDTH-bit operand per input handshake beat and collects
// four of them into one set. The set is presented on data_a..data_d with a
// valid/ready handshake.
//
// Operands 0..2 wait in a three-slot fill bank. The fourth beat copies the
// fill bank and the incoming operand into the output bank in a single step.
// This lets the next set start filling while the current set is still held.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clear      synchronous abort of a partially filled set (fill side only)
//   in_valid   producer has an operand on in_data
//   in_ready   loader accepts the operand this cycle (registers only)
//   in_data    operand value
//   out_valid  data_a..data_d hold a complete set
//   out_ready  downstream consumes the set this cycle
//   data_a..d  registered operands 0..3 of the current set
module addtree_operand_loader #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_a,
  output logic [WIDTH-1:0] data_b,
  output logic [WIDTH-1:0] data_c,
  output logic [WIDTH-1:0] data_d
);

  logic [1:0]       idx;
  logic [WIDTH-1:0] fill0;
  logic [WIDTH-1:0] fill1;
  logic [WIDTH-1:0] fill2;
  logic             accept;
  logic             complete;

  // Only the fourth beat can be blocked: it would overwrite a set that is
  // still pending. Beats 0..2 go to the fill bank, so they are always
  // accepted. in_ready depends only on registers, never on out_ready.
  always_comb begin
    in_ready = !((idx == 2'd3) && out_valid);
    accept   = in_valid && in_ready;
    // A clear in the same cycle drops the beat, including a fourth beat.
    complete = accept && !clear && (idx == 2'd3);
  end

  // Fill bank and slot index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      fill0 <= '0;
      fill1 <= '0;
      fill2 <= '0;
    end else if (clear) begin
      idx   <= '0;
      fill0 <= '0;
      fill1 <= '0;
      fill2 <= '0;
    end else if (accept) begin
      case (idx)
        2'd0:    fill0 <= in_data;
        2'd1:    fill1 <= in_data;
        2'd2:    fill2 <= in_data;
        default: ;
      endcase
      idx <= idx + 2'd1;
    end
  end

  // Output bank. A completion and a pending set never meet: completion needs
  // in_ready, and in_ready is low at idx==3 while out_valid is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_a    <= '0;
      data_b    <= '0;
      data_c    <= '0;
      data_d    <= '0;
      out_valid <= 1'b0;
    end else if (complete) begin
      data_a    <= fill0;
      data_b    <= fill1;
      data_c    <= fill2;
      data_d    <= in_data;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
